br_rs_sched: RTL and testbench

//  Branch reservation station and issue scheduler for the branch ALU (br_alu).

---
 rtl/br_rs_sched.sv | 177 +++++++++++++++++
 tb/tb_br_rs_sched.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/br_rs_sched.sv
// Branch reservation station: holds dispatched branch/jump ops until regA is
// ready, then issues the oldest ready op to br_alu with its PRF operand.
module br_rs_sched #(
    parameter int ENTRIES   = 4,
    parameter int ROB_IDX_W = 5,
    parameter int PRF_IDX_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 disp_valid_i,
    output logic                 disp_rdy_o,
    input  logic [31:0]          disp_inst_i,
    input  logic [63:0]          disp_npc_i,
    input  logic [ROB_IDX_W-1:0] disp_rob_idx_i,
    input  logic [PRF_IDX_W-1:0] disp_opa_tag_i,
    input  logic                 disp_opa_rdy_i,
    input  logic                 cdb_valid_i,
    input  logic [PRF_IDX_W-1:0] cdb_tag_i,
    output logic [PRF_IDX_W-1:0] prf_rd_idx_o,
    input  logic [63:0]          prf_rd_data_i,
    output logic                 start_o,
    output logic [31:0]          inst_o,
    output logic [63:0]          npc_o,
    output logic [63:0]          opa_o,
    output logic [ROB_IDX_W-1:0] rob_idx_o
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    // Entry state
    logic [ENTRIES-1:0]   valid_q, valid_d;
    logic [ENTRIES-1:0]   rdy_q, rdy_d;
    logic [ENTRIES-1:0]   older_q [ENTRIES];
    logic [ENTRIES-1:0]   older_d [ENTRIES];
    logic [PRF_IDX_W-1:0] tag_q   [ENTRIES];
    logic [31:0]          inst_q  [ENTRIES];
    logic [63:0]          npc_q   [ENTRIES];
    logic [ROB_IDX_W-1:0] rob_q   [ENTRIES];

    // Issue latch
    logic                 start_q;
    logic [31:0]          inst_out_q;
    logic [63:0]          npc_out_q;
    logic [63:0]          opa_out_q;
    logic [ROB_IDX_W-1:0] rob_out_q;

    logic [ENTRIES-1:0]   cand;
    logic [ENTRIES-1:0]   pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_vld;
    logic [IDX_W-1:0]     free_idx;
    logic                 alloc;
    logic                 disp_wake;

    assign cand = valid_q & rdy_q;

    // An entry wins when no other candidate is older than it.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_sel
            assign pick_oh[gi] = cand[gi] & ~(|(cand & older_q[gi]));
        end
    endgenerate

    always_comb begin
        pick_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (pick_oh[i]) pick_idx = IDX_W'(i);
        end
    end

    assign pick_vld = |pick_oh;

    always_comb begin
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    assign disp_rdy_o   = ~(&valid_q);
    assign alloc        = disp_valid_i & disp_rdy_o;
    assign disp_wake    = disp_opa_rdy_i | (cdb_valid_i && (cdb_tag_i == disp_opa_tag_i));
    assign prf_rd_idx_o = tag_q[pick_idx];

    always_comb begin
        valid_d = valid_q;
        rdy_d   = rdy_q;
        for (int i = 0; i < ENTRIES; i++) begin
            older_d[i] = older_q[i];
        end

        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && cdb_valid_i && (tag_q[i] == cdb_tag_i)) rdy_d[i] = 1'b1;
        end

        if (pick_vld) valid_d[pick_idx] = 1'b0;

        if (alloc) begin
            valid_d[free_idx] = 1'b1;
            rdy_d[free_idx]   = disp_wake;
            // New entry is younger than everything currently valid.
            older_d[free_idx] = valid_q;
            for (int i = 0; i < ENTRIES; i++) begin
                older_d[i][free_idx] = 1'b0;
            end
        end

        if (flush_i) begin
            valid_d = '0;
            rdy_d   = '0;
            for (int i = 0; i < ENTRIES; i++) begin
                older_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rdy_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                older_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rdy_q   <= rdy_d;
            for (int i = 0; i < ENTRIES; i++) begin
                older_q[i] <= older_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]  <= '0;
                inst_q[i] <= '0;
                npc_q[i]  <= '0;
                rob_q[i]  <= '0;
            end
        end else if (alloc && !flush_i) begin
            tag_q[free_idx]  <= disp_opa_tag_i;
            inst_q[free_idx] <= disp_inst_i;
            npc_q[free_idx]  <= disp_npc_i;
            rob_q[free_idx]  <= disp_rob_idx_i;
        end
    end

    // Issue fields hold their last values while nothing issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q    <= 1'b0;
            inst_out_q <= '0;
            npc_out_q  <= '0;
            opa_out_q  <= '0;
            rob_out_q  <= '0;
        end else if (flush_i) begin
            start_q <= 1'b0;
        end else begin
            start_q <= pick_vld;
            if (pick_vld) begin
                inst_out_q <= inst_q[pick_idx];
                npc_out_q  <= npc_q[pick_idx];
                opa_out_q  <= prf_rd_data_i;
                rob_out_q  <= rob_q[pick_idx];
            end
        end
    end

    assign start_o   = start_q;
    assign inst_o    = inst_out_q;
    assign npc_o     = npc_out_q;
    assign opa_o     = opa_out_q;
    assign rob_idx_o = rob_out_q;

endmodule

// File: tb/tb_br_rs_sched.sv
// Directed bench for br_rs_sched: dispatch, wakeup, oldest-first select,
// full-station handling, same-cycle CDB capture, flush and async reset.
module tb_br_rs_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        disp_valid_i;
    logic        disp_rdy_o;
    logic [31:0] disp_inst_i;
    logic [63:0] disp_npc_i;
    logic [4:0]  disp_rob_idx_i;
    logic [5:0]  disp_opa_tag_i;
    logic        disp_opa_rdy_i;
    logic        cdb_valid_i;
    logic [5:0]  cdb_tag_i;
    logic [5:0]  prf_rd_idx_o;
    logic [63:0] prf_rd_data_i;
    logic        start_o;
    logic [31:0] inst_o;
    logic [63:0] npc_o;
    logic [63:0] opa_o;
    logic [4:0]  rob_idx_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // PRF model: value is the tag replicated into four 16-bit lanes.
    assign prf_rd_data_i = 64'(prf_rd_idx_o) * 64'h0001_0001_0001_0001;

    br_rs_sched #(.ENTRIES(4), .ROB_IDX_W(5), .PRF_IDX_W(6)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .disp_valid_i   (disp_valid_i),
        .disp_rdy_o     (disp_rdy_o),
        .disp_inst_i    (disp_inst_i),
        .disp_npc_i     (disp_npc_i),
        .disp_rob_idx_i (disp_rob_idx_i),
        .disp_opa_tag_i (disp_opa_tag_i),
        .disp_opa_rdy_i (disp_opa_rdy_i),
        .cdb_valid_i    (cdb_valid_i),
        .cdb_tag_i      (cdb_tag_i),
        .prf_rd_idx_o   (prf_rd_idx_o),
        .prf_rd_data_i  (prf_rd_data_i),
        .start_o        (start_o),
        .inst_o         (inst_o),
        .npc_o          (npc_o),
        .opa_o          (opa_o),
        .rob_idx_o      (rob_idx_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [4:0] rob, input logic [5:0] tag, input logic rdy);
        disp_valid_i   = 1'b1;
        disp_rob_idx_i = rob;
        disp_opa_tag_i = tag;
        disp_opa_rdy_i = rdy;
        disp_inst_i    = 32'h0000_0063 | (32'(rob) << 20);
        disp_npc_i     = 64'h1000 + 64'(rob) * 4;
    endtask

    task automatic idle();
        disp_valid_i = 1'b0;
        cdb_valid_i  = 1'b0;
        flush_i      = 1'b0;
    endtask

    task automatic chk_issue(input string tag, input logic [4:0] rob, input logic [5:0] ptag);
        chk({tag, "_start"}, 64'(start_o), 64'd1);
        chk({tag, "_rob"}, 64'(rob_idx_o), 64'(rob));
        chk({tag, "_inst"}, 64'(inst_o), 64'(32'h0000_0063 | (32'(rob) << 20)));
        chk({tag, "_npc"}, npc_o, 64'h1000 + 64'(rob) * 4);
        chk({tag, "_opa"}, opa_o, 64'(ptag) * 64'h0001_0001_0001_0001);
        $display("issue %s rob=%0d opa=%h", tag, rob_idx_o, opa_o);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        disp_inst_i = '0; disp_npc_i = '0; disp_rob_idx_i = '0;
        disp_opa_tag_i = '0; disp_opa_rdy_i = 1'b0; cdb_tag_i = '0;
        #12;
        chk("rst_start", 64'(start_o), 64'd0);
        chk("rst_rdy", 64'(disp_rdy_o), 64'd1);
        chk("rst_rob", 64'(rob_idx_o), 64'd0);
        chk("rst_opa", opa_o, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: ready-at-dispatch BEQ issues two edges after dispatch
        disp(5'd3, 6'd0, 1'b1);
        tick(); idle();
        chk("t1_nostart", 64'(start_o), 64'd0);
        tick();
        chk_issue("t1", 5'd3, 6'd0);
        tick();
        chk("t1_freed", 64'(start_o), 64'd0);
        chk("t1_hold_rob", 64'(rob_idx_o), 64'd3);

        // 2: ready op bypasses older waiting op; CDB wakeup latency
        disp(5'd1, 6'd9, 1'b0); tick();
        disp(5'd2, 6'd5, 1'b1); tick(); idle();
        chk("t2_prfidx", 64'(prf_rd_idx_o), 64'd5);
        tick();
        chk_issue("t2a", 5'd2, 6'd5);
        cdb_valid_i = 1'b1; cdb_tag_i = 6'd9;
        tick(); idle();
        chk("t2_wait", 64'(start_o), 64'd0);
        tick();
        chk_issue("t2b", 5'd1, 6'd9);

        // 3: single wakeup of three entries, oldest first
        disp(5'd5, 6'd12, 1'b0); tick();
        disp(5'd6, 6'd12, 1'b0); tick();
        disp(5'd7, 6'd12, 1'b0); tick(); idle();
        cdb_valid_i = 1'b1; cdb_tag_i = 6'd12;
        tick(); idle();
        chk("t3_wait", 64'(start_o), 64'd0);
        tick(); chk_issue("t3a", 5'd5, 6'd12);
        tick(); chk_issue("t3b", 5'd6, 6'd12);
        tick(); chk_issue("t3c", 5'd7, 6'd12);
        tick();
        chk("t3_done", 64'(start_o), 64'd0);

        // 4: fill station, dispatch while full is dropped
        disp(5'd8, 6'd20, 1'b0); tick();
        disp(5'd9, 6'd21, 1'b0); tick();
        disp(5'd10, 6'd22, 1'b0); tick();
        disp(5'd11, 6'd23, 1'b0); tick(); idle();
        chk("t4_full", 64'(disp_rdy_o), 64'd0);
        disp(5'd15, 6'd21, 1'b1); tick(); idle();
        chk("t4_full_ign", 64'(start_o), 64'd0);
        cdb_valid_i = 1'b1; cdb_tag_i = 6'd21;
        tick(); idle();
        chk("t4_still_full", 64'(disp_rdy_o), 64'd0);
        tick();
        chk_issue("t4a", 5'd9, 6'd21);
        chk("t4_rdy_after", 64'(disp_rdy_o), 64'd1);
        // new ready op lands in freed slot 1; older slot 3 woken same cycle must win
        disp(5'd12, 6'd30, 1'b1);
        cdb_valid_i = 1'b1; cdb_tag_i = 6'd23;
        tick(); idle();
        chk("t4_wait", 64'(start_o), 64'd0);
        tick(); chk_issue("t4b", 5'd11, 6'd23);
        tick(); chk_issue("t4c", 5'd12, 6'd30);
        tick();
        chk("t4_done", 64'(start_o), 64'd0);

        // 5: dispatch captures same-cycle CDB broadcast
        disp(5'd13, 6'd40, 1'b0);
        cdb_valid_i = 1'b1; cdb_tag_i = 6'd40;
        tick(); idle();
        tick();
        chk_issue("t5", 5'd13, 6'd40);

        // 6: flush with three valid entries and an issue pending
        disp(5'd14, 6'd41, 1'b1); tick(); idle();
        flush_i = 1'b1;
        disp(5'd16, 6'd42, 1'b1);
        cdb_valid_i = 1'b1; cdb_tag_i = 6'd20;
        tick(); idle();
        chk("t6_start", 64'(start_o), 64'd0);
        chk("t6_rdy", 64'(disp_rdy_o), 64'd1);
        cdb_valid_i = 1'b1; cdb_tag_i = 6'd20; tick();
        cdb_tag_i = 6'd22; tick(); idle();
        chk("t6_q1", 64'(start_o), 64'd0);
        tick();
        chk("t6_q2", 64'(start_o), 64'd0);
        tick();
        chk("t6_q3", 64'(start_o), 64'd0);

        // async reset while start_o is high
        disp(5'd4, 6'd0, 1'b1); tick(); idle();
        tick();
        chk_issue("t6r", 5'd4, 6'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_start", 64'(start_o), 64'd0);
        chk("t6_async_rob", 64'(rob_idx_o), 64'd0);
        #1 rst_n = 1'b1;
        tick();
        chk("t6_post_rst", 64'(start_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
